// File: rtl/uvc_lane_mux.sv
// Read-mode selector between frame-buffer byte lanes and internal test patterns (ramp, bars, black).
// Latency 1 cycle from re to y_valid; no backpressure, and mode changes take effect only at a vblank rise.
module uvc_lane_mux #(
    parameter int DATA_WD     = 16,
    parameter int LANE_WD     = 8,
    parameter int NUM_LANES   = DATA_WD / LANE_WD,
    parameter int LINE_PIX    = 480,
    parameter int FRAME_LINES = 360,
    parameter int MODE_W      = $clog2(NUM_LANES + 3)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           step,
    input  logic                           mode_load,
    input  logic [MODE_W-1:0]              mode_in,
    input  logic                           vblank,
    input  logic                           re,
    input  logic                           din_valid,
    input  logic [DATA_WD-1:0]             din,
    output logic [LANE_WD+15:0]            yuv_out,
    output logic                           y_valid,
    output logic [MODE_W-1:0]              mode_cur,
    output logic [MODE_W-1:0]              mode_pend,
    output logic [NUM_LANES+2:0]           led,
    output logic [$clog2(LINE_PIX)-1:0]    pix_x,
    output logic [$clog2(FRAME_LINES)-1:0] pix_y,
    output logic                           overrun,
    output logic                           underrun
);

    localparam int NUM_MODES = NUM_LANES + 3;
    localparam int M_RAMP    = NUM_LANES;
    localparam int M_BARS    = NUM_LANES + 1;
    localparam int XW        = $clog2(LINE_PIX);
    localparam int YW        = $clog2(FRAME_LINES);
    localparam int BW        = (LINE_PIX / 8 > 0) ? LINE_PIX / 8 : 1;
    localparam int SW        = (BW > 1) ? $clog2(BW) : 1;

    localparam logic [XW-1:0]     LAST_X  = XW'(LINE_PIX - 1);
    localparam logic [YW-1:0]     LAST_Y  = YW'(FRAME_LINES - 1);
    localparam logic [SW-1:0]     LAST_S  = SW'(BW - 1);
    localparam logic [MODE_W-1:0] LAST_M  = MODE_W'(NUM_MODES - 1);

    function automatic logic [7:0] bar_luma(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_luma = 8'hEB;
            3'd1:    bar_luma = 8'hD2;
            3'd2:    bar_luma = 8'hAA;
            3'd3:    bar_luma = 8'h91;
            3'd4:    bar_luma = 8'h6A;
            3'd5:    bar_luma = 8'h51;
            3'd6:    bar_luma = 8'h29;
            default: bar_luma = 8'h10;
        endcase
    endfunction

    logic               vblank_q;
    logic               vb_rise;
    logic               pix_en;
    logic               eof;
    logic [SW-1:0]      bar_sub;
    logic [2:0]         bar_idx;
    logic [LANE_WD-1:0] y_q;
    logic [LANE_WD-1:0] y_nxt;
    logic [LANE_WD-1:0] lane_y;
    logic               lane_hit;
    logic [7:0]         ramp8;

    assign vb_rise = vblank & ~vblank_q;
    assign pix_en  = re & ~vblank;
    assign yuv_out = {y_q, 8'h80, 8'h80};

    // Staged mode: an explicit load wins over a step; illegal loads are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_pend <= '0;
        end else if (mode_load) begin
            if (int'(mode_in) < NUM_MODES)
                mode_pend <= mode_in;
        end else if (step) begin
            mode_pend <= (mode_pend == LAST_M) ? '0 : mode_pend + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblank_q <= 1'b0;
            mode_cur <= '0;
        end else begin
            vblank_q <= vblank;
            if (vb_rise)
                mode_cur <= mode_pend;
        end
    end

    // Position tracking; once the last pixel of the frame is consumed the counters park until vblank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_x   <= '0;
            pix_y   <= '0;
            eof     <= 1'b0;
            bar_sub <= '0;
            bar_idx <= '0;
        end else if (vb_rise) begin
            pix_x   <= '0;
            pix_y   <= '0;
            eof     <= 1'b0;
            bar_sub <= '0;
            bar_idx <= '0;
        end else if (pix_en && !eof) begin
            if (pix_x == LAST_X) begin
                if (pix_y == LAST_Y) begin
                    eof <= 1'b1;
                end else begin
                    pix_x   <= '0;
                    pix_y   <= pix_y + 1'b1;
                    bar_sub <= '0;
                    bar_idx <= '0;
                end
            end else begin
                pix_x <= pix_x + 1'b1;
                if (bar_sub == LAST_S) begin
                    bar_sub <= '0;
                    if (bar_idx != 3'd7)
                        bar_idx <= bar_idx + 1'b1;
                end else begin
                    bar_sub <= bar_sub + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else if (vb_rise) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else if (pix_en) begin
            if (eof)
                overrun <= 1'b1;
            else if (lane_hit && !din_valid)
                underrun <= 1'b1;
        end
    end

    always_comb begin
        lane_y   = '0;
        lane_hit = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (mode_cur == MODE_W'(k)) begin
                lane_y   = din[k*LANE_WD +: LANE_WD];
                lane_hit = 1'b1;
            end
        end
    end

    assign ramp8 = 8'(pix_x);

    always_comb begin
        y_nxt = '0;
        if (eof)
            y_nxt = '0;
        else if (lane_hit)
            y_nxt = din_valid ? lane_y : '0;
        else if (mode_cur == MODE_W'(M_RAMP))
            y_nxt = LANE_WD'(ramp8) << (LANE_WD - 8);
        else if (mode_cur == MODE_W'(M_BARS))
            y_nxt = LANE_WD'(bar_luma(bar_idx)) << (LANE_WD - 8);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= pix_en;
            if (pix_en)
                y_q <= y_nxt;
        end
    end

    // Active-low one-hot of the committed mode.
    always_comb begin
        led = '1;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (mode_cur == MODE_W'(k))
                led[k] = 1'b0;
        end
    end

endmodule

// File: tb/tb_uvc_lane_mux.sv
// Directed bench for uvc_lane_mux; frame height is shortened so a whole frame fits the cycle budget.
module tb_uvc_lane_mux;

    localparam int LP = 480;
    localparam int FL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        step;
    logic        mode_load;
    logic [2:0]  mode_in;
    logic        vblank;
    logic        re;
    logic        din_valid;
    logic [15:0] din;
    logic [23:0] yuv_out;
    logic        y_valid;
    logic [2:0]  mode_cur;
    logic [2:0]  mode_pend;
    logic [4:0]  led;
    logic [8:0]  pix_x;
    logic [1:0]  pix_y;
    logic        overrun;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] bars [8] = '{8'hEB, 8'hD2, 8'hAA, 8'h91, 8'h6A, 8'h51, 8'h29, 8'h10};

    uvc_lane_mux #(.FRAME_LINES(FL)) dut (
        .clk(clk), .rst(rst), .step(step), .mode_load(mode_load), .mode_in(mode_in),
        .vblank(vblank), .re(re), .din_valid(din_valid), .din(din),
        .yuv_out(yuv_out), .y_valid(y_valid), .mode_cur(mode_cur), .mode_pend(mode_pend),
        .led(led), .pix_x(pix_x), .pix_y(pix_y), .overrun(overrun), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " mode_cur"}, mode_cur, 0);
        check({tag, " mode_pend"}, mode_pend, 0);
        check({tag, " yuv"}, yuv_out, 24'h008080);
        check({tag, " y_valid"}, y_valid, 0);
        check({tag, " pix_x"}, pix_x, 0);
        check({tag, " pix_y"}, pix_y, 0);
        check({tag, " overrun"}, overrun, 0);
        check({tag, " underrun"}, underrun, 0);
        check({tag, " led"}, led, 5'b11110);
    endtask

    initial begin
        rst = 1'b1; step = 0; mode_load = 0; mode_in = 0; vblank = 0;
        re = 0; din_valid = 0; din = 16'h0000;
        tick(); tick();
        check_reset("reset");
        rst = 1'b0;
        din = 16'hA55A; din_valid = 1;
        tick();

        // Lane 0 pass-through, one idle cycle between reads.
        for (int i = 0; i < 3; i++) begin
            re = 1; tick(); re = 0;
            check("lane0 valid", y_valid, 1);
            check("lane0 yuv", yuv_out, 24'h5A8080);
            tick();
            check("idle valid", y_valid, 0);
            check("idle hold", yuv_out, 24'h5A8080);
        end
        check("pix_x after 3", pix_x, 3);

        // Step is staged; commit only at the vblank rise.
        step = 1; tick(); step = 0;
        check("step pend", mode_pend, 1);
        check("step cur held", mode_cur, 0);
        tick();
        check("cur before rise", mode_cur, 0);
        vblank = 1; tick();
        check("cur at rise", mode_cur, 1);
        check("rise pix_x", pix_x, 0);
        check("led lane1", led, 5'b11101);
        vblank = 0; tick();
        re = 1; tick(); re = 0;
        check("lane1 yuv", yuv_out, 24'hA58080);
        check("lane1 valid", y_valid, 1);

        // Load beats step; illegal load ignored; step wraps.
        step = 1; mode_load = 1; mode_in = 3'd4; tick();
        step = 0; mode_load = 0;
        check("load prio", mode_pend, 4);
        mode_load = 1; mode_in = 3'd7; tick(); mode_load = 0;
        check("illegal load", mode_pend, 4);
        for (int i = 0; i < 4; i++) begin
            step = 1; tick(); step = 0;
            check("step wrap", mode_pend, i);
        end

        // Step coincident with the vblank rise: commits old pending, new value waits.
        vblank = 1; step = 1; tick(); step = 0;
        check("rise+step cur", mode_cur, 3);
        check("rise+step pend", mode_pend, 4);
        check("led bars", led, 5'b10111);
        vblank = 0; tick();

        // Colour bars over one full line.
        re = 1;
        for (int i = 0; i < LP; i++) begin
            tick();
            check("bars", yuv_out, {bars[i / 60], 16'h8080});
        end
        re = 0;
        check("bars pix_x", pix_x, 0);
        check("bars pix_y", pix_y, 1);

        // Ramp mode; re during vblank must be ignored.
        mode_load = 1; mode_in = 3'd2; tick(); mode_load = 0;
        vblank = 1; tick();
        check("ramp commit", mode_cur, 2);
        re = 1; tick(); re = 0;
        check("vblank re valid", y_valid, 0);
        check("vblank re pix_x", pix_x, 0);
        vblank = 0; tick();

        re = 1;
        for (int i = 0; i < LP * FL; i++) begin
            tick();
            check("ramp", yuv_out, {8'(i % LP), 16'h8080});
        end
        re = 0;
        check("eof pix_x", pix_x, LP - 1);
        check("eof pix_y", pix_y, FL - 1);
        check("eof no overrun", overrun, 0);
        re = 1; tick(); re = 0;
        check("overrun valid", y_valid, 1);
        check("overrun black", yuv_out, 24'h008080);
        check("overrun flag", overrun, 1);
        check("overrun pix_x", pix_x, LP - 1);
        check("overrun pix_y", pix_y, FL - 1);
        vblank = 1; tick();
        check("clr overrun", overrun, 0);
        check("clr pix_x", pix_x, 0);
        check("clr pix_y", pix_y, 0);
        vblank = 0; tick();

        // Underrun in lane 1, then reset mid-line.
        mode_load = 1; mode_in = 3'd1; tick(); mode_load = 0;
        vblank = 1; tick(); vblank = 0; tick();
        check("lane1 commit", mode_cur, 1);
        din_valid = 0; re = 1; tick(); re = 0;
        check("underrun yuv", yuv_out, 24'h008080);
        check("underrun flag", underrun, 1);
        check("underrun valid", y_valid, 1);
        din_valid = 1; re = 1; tick(); re = 0;
        check("after underrun yuv", yuv_out, 24'hA58080);
        check("underrun sticky", underrun, 1);
        check("mid pix_x", pix_x, 2);

        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset("async reset");
        tick(); tick();
        rst = 1'b0;
        re = 1; tick(); re = 0;
        check("post reset yuv", yuv_out, 24'h5A8080);
        check("post reset pix_x", pix_x, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uvc_lane_mux.md
Name: uvc_lane_mux

Overview:
- Parametrised successor to the top-level read-mode selector between the DDR3 frame-buffer read port and the UVC YUV input, in the ulpi_clk domain.
- Selects one byte lane of an N-lane frame-buffer word, or an internal test pattern (grey ramp, 8 colour bars, black).
- Mode changes are staged and committed only at the start of vertical blanking, so a frame is never torn.
- Tracks pixel/line position, reports overrun/underrun, and drives a mode LED vector.

Parameters:
- DATA_WD, 16, frame-buffer read word width; must be a multiple of LANE_WD.
- LANE_WD, 8, luma width per lane; 8 or greater.
- NUM_LANES, DATA_WD/LANE_WD, derived; number of selectable lanes.
- LINE_PIX, 480, pixels per line.
- FRAME_LINES, 360, lines per frame.
- MODE_W, $clog2(NUM_LANES+3), derived; mode code width.

Ports:
- clk  in  1  ulpi_clk domain clock.
- rst  in  1  asynchronous, active-high reset.
- step  in  1  single-cycle pulse (debounced, edge-detected key); advances pending mode.
- mode_load  in  1  load mode_in into pending mode.
- mode_in  in  MODE_W  mode to load.
- vblank  in  1  high during vertical blanking (the UVC vs inverted).
- re  in  1  pixel read strobe from UVC.
- din_valid  in  1  frame-buffer read data valid.
- din  in  DATA_WD  frame-buffer read word.
- yuv_out  out  LANE_WD+16  {y, 8'h80, 8'h80}.
- y_valid  out  1  yuv_out updated this cycle.
- mode_cur  out  MODE_W  active (committed) mode.
- mode_pend  out  MODE_W  staged mode.
- led  out  NUM_LANES+3  one-hot of mode_cur, active-low.
- pix_x  out  $clog2(LINE_PIX)  current pixel index.
- pix_y  out  $clog2(FRAME_LINES)  current line index.
- overrun  out  1  sticky; re after the last pixel of the frame.
- underrun  out  1  sticky; re in a lane mode while din_valid is 0.

Behaviour:
- Modes:
  - 0..NUM_LANES-1: lane k, y = din[k*LANE_WD +: LANE_WD].
  - NUM_LANES: RAMP, y = pix_x[7:0] << (LANE_WD-8).
  - NUM_LANES+1: BARS.
  - NUM_LANES+2: BLACK, y = 0.
  - Codes at or above NUM_LANES+3 are illegal.
- Reset values: mode_cur=0, mode_pend=0, yuv_out={0,8'h80,8'h80}, y_valid=0, pix_x=0, pix_y=0, overrun=0, underrun=0, led=~1.
- Pending mode:
  - mode_load has priority over step in the same cycle.
  - An illegal mode_in is ignored (pending unchanged).
  - step increments pending, wrapping from NUM_LANES+2 to 0.
  - mode_pend reflects the change on the next edge.
- Commit:
  - On the rising edge of vblank (registered previous-cycle vblank = 0, current = 1), mode_cur <= mode_pend on that edge.
  - A step in the same cycle as the vblank rise updates pending only; it commits at the next frame.
  - The same vblank-rise cycle also clears pix_x, pix_y, overrun, underrun and the bar state.
- Pixel position:
  - Each re outside vblank increments pix_x.
  - At LINE_PIX-1, pix_x wraps to 0 and pix_y increments.
  - re at pix_x=LINE_PIX-1 and pix_y=FRAME_LINES-1 sets end-of-frame.
  - Further re before vblank sets overrun; counters hold and output is black.
  - re during vblank is ignored: no counters change, y_valid=0.
- Output:
  - Registered, latency 1 cycle: on re (outside vblank), y_valid=1 next cycle with y computed from the mode_cur, din and pix_x sampled at the re cycle.
  - Otherwise y_valid=0 and yuv_out holds its value.
  - In a lane mode with re=1 and din_valid=0: y=0 and underrun is set.
- BARS:
  - Bar width BW = LINE_PIX/8, using a sub-counter and 3-bit bar index, no divider.
  - Bar index increments when the sub-counter reaches BW-1 and saturates at 7.
  - Bar index resets at line wrap.
  - Luma (8-bit, left-shifted by LANE_WD-8): EB, D2, AA, 91, 6A, 51, 29, 10.
- led: bit mode_cur low, all others high.
- Reset mid-frame: all state returns to reset values; the first frame after reset runs in mode 0 without waiting for vblank.

Test Plan:
- Reset, mode 0, din=16'hA55A with din_valid, 3 re pulses outside vblank -> y_valid=1 one cycle after each re; yuv_out=24'h5A8080; pix_x 0->3.
- step, then vblank rise -> mode_pend=1 the next cycle and mode_cur=1 at the rise; before the rise mode_cur stays 0; next frame yuv_out=24'hA58080.
- step and mode_load(mode_in=4) in the same cycle -> mode_pend=4. Separately, mode_in=7 -> ignored. Four steps from pend=4 -> 4,0,1,2,3.
- BARS mode, 480 re -> y=EB for pixels 0-59, D2 for 60-119, ..., 10 for 420-479; pix_y=1 after the last pixel.
- Full 480x360 frame then one extra re -> overrun=1, output black, counters hold; vblank rise -> overrun=0, pix_x=pix_y=0.
- Lane mode, re with din_valid=0 -> yuv_out=24'h008080 and underrun=1. Assert rst mid-line -> all outputs return to reset values asynchronously.
